// File: rtl/uart_tx_fifo_pkg.sv
// +----------------------------------------------------------------------------+
// | uart_tx_fifo_pkg: shared defaults, FSM encodings and MMIO offsets.          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_tx_fifo_pkg;

  localparam int c_CLK_DIV_DEF    = 868;
  localparam int c_FIFO_DEPTH_DEF = 16;

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t c_ST_IDLE  = 2'd0;
  localparam tx_state_t c_ST_START = 2'd1;
  localparam tx_state_t c_ST_DATA  = 2'd2;
  localparam tx_state_t c_ST_STOP  = 2'd3;

  // Byte offsets seen by the bus decoder in front of this block
  localparam logic [7:0] c_UART_TX_DATA_OFS = 8'h00;
  localparam logic [7:0] c_UART_TX_STAT_OFS = 8'h04;
  localparam logic [7:0] c_UART_TX_CTRL_OFS = 8'h08;

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo_sync_fifo.sv
// +----------------------------------------------------------------------------+
// | sync_fifo: single-clock FIFO, head entry visible with no read latency.      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LW-1:0]    r_wptr;
  logic [LW-1:0]    r_rptr;
  logic             w_push;
  logic             w_pop;

  // Full is sampled before any same-cycle pop, so a pop never frees a slot early
  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + LW'(1);
      if (w_pop)  r_rptr <= r_rptr + LW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= push_data_i;
  end

  assign empty_o = (r_wptr == r_rptr);
  assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign level_o = r_wptr - r_rptr;
  assign head_o  = r_mem[r_rptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// +----------------------------------------------------------------------------+
// | uart_tx_fifo: buffered 8N1 UART transmitter; UART_TX_OVF_EN adds a sticky   |
// | overflow flag. Rev 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter  int CLK_DIV    = c_CLK_DIV_DEF,
  parameter  int FIFO_DEPTH = c_FIFO_DEPTH_DEF,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  output logic          full_o,
  output logic          empty_o,
  output logic          busy_o,
  output logic [LW-1:0] level_o,
  output logic          txd_o
`ifdef UART_TX_OVF_EN
  ,
  output logic          ovf_o,
  input  logic          ovf_clr_i
`endif
);

  localparam logic [15:0] c_BRELOAD = 16'(CLK_DIV - 1);

  tx_state_t   r_state;
  tx_state_t   w_state_nx;
  logic [15:0] r_bcnt;
  logic [15:0] w_bcnt_nx;
  logic [2:0]  r_bidx;
  logic [2:0]  w_bidx_nx;
  logic [7:0]  r_shreg;
  logic [7:0]  w_shreg_nx;
  logic        r_txd;
  logic        w_txd_nx;
  logic        w_pop;
  logic [7:0]  w_head;
  logic        w_full;
  logic        w_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (wr_en_i),
    .push_data_i (wr_data_i),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .level_o     (level_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= c_ST_IDLE;
      r_bcnt  <= '0;
      r_bidx  <= '0;
      r_shreg <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_bcnt  <= w_bcnt_nx;
      r_bidx  <= w_bidx_nx;
      r_shreg <= w_shreg_nx;
      r_txd   <= w_txd_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_bcnt_nx  = r_bcnt;
    w_bidx_nx  = r_bidx;
    w_shreg_nx = r_shreg;
    w_pop      = 1'b0;
    if (r_state != c_ST_IDLE) w_bcnt_nx = r_bcnt - 16'd1;
    case (r_state)
      c_ST_IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_shreg_nx = w_head;
          w_bcnt_nx  = c_BRELOAD;
          w_state_nx = c_ST_START;
        end
      end
      c_ST_START: begin
        if (r_bcnt == 16'd0) begin
          w_state_nx = c_ST_DATA;
          w_bidx_nx  = 3'd0;
          w_bcnt_nx  = c_BRELOAD;
        end
      end
      c_ST_DATA: begin
        if (r_bcnt == 16'd0) begin
          w_shreg_nx = {1'b0, r_shreg[7:1]};
          w_bcnt_nx  = c_BRELOAD;
          if (r_bidx == 3'd7) w_state_nx = c_ST_STOP;
          else                w_bidx_nx  = r_bidx + 3'd1;
        end
      end
      default: begin
        if (r_bcnt == 16'd0) begin
          // Chain straight into the next start bit when more data is queued
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_shreg_nx = w_head;
            w_bcnt_nx  = c_BRELOAD;
            w_state_nx = c_ST_START;
          end else begin
            w_bcnt_nx  = 16'd0;
            w_state_nx = c_ST_IDLE;
          end
        end
      end
    endcase
  end

  // Line level is derived from the upcoming state so txd_o stays registered
  always_comb begin
    w_txd_nx = 1'b1;
    case (w_state_nx)
      c_ST_START: w_txd_nx = 1'b0;
      c_ST_DATA:  w_txd_nx = w_shreg_nx[0];
      default:    w_txd_nx = 1'b1;
    endcase
  end

  assign txd_o   = r_txd;
  assign busy_o  = (r_state != c_ST_IDLE);
  assign full_o  = w_full;
  assign empty_o = w_empty;

`ifdef UART_TX_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                r_ovf <= 1'b0;
    else if (wr_en_i && w_full) r_ovf <= 1'b1;
    else if (ovf_clr_i)         r_ovf <= 1'b0;
  end

  assign ovf_o = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// +----------------------------------------------------------------------------+
// | tb_uart_tx_fifo: directed stimulus with a serial-decoding scoreboard.       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_fifo;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int LW         = 3;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          wr_en   = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          full;
  logic          empty;
  logic          busy;
  logic [LW-1:0] level;
  logic          txd;
`ifdef UART_TX_OVF_EN
  logic          ovf;
  logic          ovf_clr = 1'b0;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .full_o    (full),
    .empty_o   (empty),
    .busy_o    (busy),
    .level_o   (level),
    .txd_o     (txd)
`ifdef UART_TX_OVF_EN
    ,
    .ovf_o     (ovf),
    .ovf_clr_i (ovf_clr)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [7:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) exp_q.push_back(d);
    tick;
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (busy && n < limit) begin
      tick;
      n++;
    end
  endtask

  // Serial monitor: decodes 8N1 frames mid-bit and pops the expected byte
  int         rx_cnt    = 0;
  bit         rx_active = 1'b0;
  logic [7:0] rx_byte   = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (txd == 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == CLK_DIV / 2) begin
        check("rx_start_bit", 32'(txd), 32'd0);
      end else if (rx_cnt > CLK_DIV && rx_cnt < 9 * CLK_DIV && (rx_cnt % CLK_DIV) == CLK_DIV / 2) begin
        rx_byte[rx_cnt / CLK_DIV - 1] = txd;
      end else if (rx_cnt == 9 * CLK_DIV + CLK_DIV / 2) begin
        check("rx_stop_bit", 32'(txd), 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_unexpected: got 0x%0h, expected no frame", rx_byte);
        end else begin
          check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
        end
        rx_active = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frame;
    int         n;
    int         highs;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_level", 32'(level), 32'd0);
`ifdef UART_TX_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    tick;
    check("idle_txd", 32'(txd), 32'd1);

    // Single 0x55 frame, cycle-exact waveform
    frame = {1'b1, 8'h55, 1'b0};
    write(8'h55, 1'b1);
    check("t1_empty_n1", 32'(empty), 32'd0);
    check("t1_txd_n1", 32'(txd), 32'd1);
    tick;
    for (int i = 0; i < 10 * CLK_DIV; i++) begin
      check("t1_txd_wave", 32'(txd), 32'(frame[i / CLK_DIV]));
      check("t1_busy_wave", 32'(busy), 32'd1);
      tick;
    end
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_txd_end", 32'(txd), 32'd1);
    check("t1_empty_end", 32'(empty), 32'd1);

    // Three back-to-back bytes, no idle gap between frames
    repeat (3) tick;
    write(8'h41, 1'b1);
    check("t2_level_a", 32'(level), 32'd1);
    write(8'h42, 1'b1);
    check("t2_level_b", 32'(level), 32'd1);
    write(8'h43, 1'b1);
    check("t2_level_peak", 32'(level), 32'd2);
    wait_idle(1000, n);
    check("t2_busy_cycles", 32'(n), 32'd119);
    check("t2_level_end", 32'(level), 32'd0);

    // Fill to full, then a dropped write
    repeat (2) tick;
    write(8'h00, 1'b1);
    check("t3_level0", 32'(level), 32'd1);
    write(8'h01, 1'b1);
    check("t3_level1", 32'(level), 32'd1);
    write(8'h02, 1'b1);
    check("t3_level2", 32'(level), 32'd2);
    write(8'h03, 1'b1);
    check("t3_level3", 32'(level), 32'd3);
    write(8'h04, 1'b1);
    check("t3_level4", 32'(level), 32'd4);
    check("t3_full", 32'(full), 32'd1);
    write(8'h05, 1'b0);
    check("t3_level_drop", 32'(level), 32'd4);
    check("t3_full_drop", 32'(full), 32'd1);
`ifdef UART_TX_OVF_EN
    check("t3_ovf_set", 32'(ovf), 32'd1);
`endif

    // Write while full on the same cycle the stop bit completes and pops
    repeat (35) tick;
    check("t4_level_pre", 32'(level), 32'd4);
    check("t4_full_pre", 32'(full), 32'd1);
    write(8'h77, 1'b0);
    check("t4_level_post", 32'(level), 32'd3);
    check("t4_full_post", 32'(full), 32'd0);
`ifdef UART_TX_OVF_EN
    check("t4_ovf_still", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    check("t6_ovf_clr", 32'(ovf), 32'd0);
`else
    tick;
`endif
    write(8'h78, 1'b1);
    check("t6_full_again", 32'(full), 32'd1);
`ifdef UART_TX_OVF_EN
    ovf_clr = 1'b1;
`endif
    write(8'h79, 1'b0);
`ifdef UART_TX_OVF_EN
    ovf_clr = 1'b0;
    check("t6_set_beats_clr", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    check("t6_ovf_clr2", 32'(ovf), 32'd0);
`endif
    wait_idle(2000, n);
    check("t4_drain_busy", 32'(busy), 32'd0);
    check("t4_drain_level", 32'(level), 32'd0);
    check("t4_drain_empty", 32'(empty), 32'd1);

    // Reset in the middle of 0xA5 data bits with two bytes queued
    tick;
    write(8'hA5, 1'b1);
    write(8'h11, 1'b1);
    write(8'h22, 1'b1);
    check("t5_level_q", 32'(level), 32'd2);
    repeat (10) tick;
    check("t5_txd_bit1", 32'(txd), 32'd0);
    check("t5_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t5_txd_async", 32'(txd), 32'd1);
    check("t5_empty", 32'(empty), 32'd1);
    check("t5_level", 32'(level), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    tick;
    tick;
    rst_n = 1'b1;
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (txd === 1'b1) highs++;
    end
    check("t5_line_idle", 32'(highs), 32'd100);
    check("t5_busy_after", 32'(busy), 32'd0);

    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
